// File: rtl/bcd_pkg.sv
// Shared types and constants for the digit-serial BCD adder.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int           DIGIT_W  = 4;
  localparam logic [3:0]   BCD_MAX  = 4'd9;
  localparam logic [4:0]   BCD_BASE = 5'd10;

endpackage

// File: rtl/bcd_digit_add.sv
// Combinational single-digit BCD adder; the one shared resource the controller sequences.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] x,
  input  logic [DIGIT_W-1:0] y,
  input  logic               c,
  output logic [DIGIT_W-1:0] digit,
  output logic               carry,
  output logic               bad
);

  logic [DIGIT_W:0] raw;
  logic [DIGIT_W:0] adj;

  // Binary add, then fold back by 10 when past 9. Illegal digits follow the
  // same rule (low nibble of raw-10), so the result stays deterministic.
  always_comb begin
    raw   = {1'b0, x} + {1'b0, y} + {{DIGIT_W{1'b0}}, c};
    adj   = raw - BCD_BASE;
    bad   = (x > BCD_MAX) || (y > BCD_MAX);
    if (raw > {1'b0, BCD_MAX}) begin
      digit = adj[DIGIT_W-1:0];
      carry = 1'b1;
    end else begin
      digit = raw[DIGIT_W-1:0];
      carry = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial multi-digit BCD adder controller: one digit per clock, LSD first.
module bcd_serial_add_ctrl
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  cin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  error
);

  localparam int W  = DIGIT_W * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  state_t              state, nstate;
  logic [W-1:0]        sa, sb, sreg;
  logic                carry, err;
  logic [IW-1:0]       idx;
  logic                accept, step, last;

  logic [DIGIT_W-1:0]  d;
  logic                dc, dbad;

  // Operand shift registers always present the current digit in the low nibble.
  bcd_digit_add u_add (
    .x     (sa[DIGIT_W-1:0]),
    .y     (sb[DIGIT_W-1:0]),
    .c     (carry),
    .digit (d),
    .carry (dc),
    .bad   (dbad)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  // Next-state and Moore outputs; start is only looked at in IDLE.
  always_comb begin
    nstate = state;
    busy   = 1'b0;
    done   = 1'b0;
    accept = 1'b0;
    step   = 1'b0;
    last   = (idx == LAST);
    unique case (state)
      IDLE: begin
        if (start) begin
          accept = 1'b1;
          nstate = ADD;
        end
      end
      ADD: begin
        busy = 1'b1;
        step = 1'b1;
        if (last) nstate = DONE;
      end
      DONE: begin
        done   = 1'b1;
        nstate = IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

  // Datapath: capture on accept, shift one digit per ADD cycle, hold otherwise.
  // Result digits enter at the top of sreg so digit 0 lands in [3:0] at the end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa    <= '0;
      sb    <= '0;
      sreg  <= '0;
      carry <= 1'b0;
      err   <= 1'b0;
      idx   <= '0;
    end else if (accept) begin
      sa    <= a;
      sb    <= b;
      carry <= cin;
      err   <= 1'b0;
      idx   <= '0;
    end else if (step) begin
      sa    <= sa >> DIGIT_W;
      sb    <= sb >> DIGIT_W;
      sreg  <= (sreg >> DIGIT_W) | (W'(d) << (W - DIGIT_W));
      carry <= dc;
      err   <= err | dbad;
      idx   <= idx + 1'b1;
    end
  end

  // carry register doubles as cout: after the last digit it holds the top carry.
  assign sum   = sreg;
  assign cout  = carry;
  assign error = err;

endmodule
